// File: rtl/alu_issue_wb.sv
// ----------------------------------------------------------------------------
// alu_issue_wb
//
// Operand-issue and writeback stage wrapped around an external combinational
// ALU. Owns the integer register file, takes decoded instructions over a
// valid/ready handshake, registers ALU operands/opcode for one cycle and
// writes the ALU result back on the following edge. The result that is about
// to be written is forwarded to the operand read of the instruction being
// accepted in the same cycle, so dependent back-to-back instructions never
// stall.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready decoded-instruction handshake (in_ready = !stall)
//   in_rs1/in_rs2     source registers for operand A / operand B
//   in_rd             destination register
//   in_imm/in_use_imm immediate and operand-B select
//   in_alu_sel        ALU opcode, passed through unchanged
//   stall             freezes issue and writeback
//   alu_a/alu_b       registered operands to the ALU
//   alu_sel           registered opcode to the ALU
//   alu_valid         issue register holds a live instruction
//   alu_result        combinational ALU result (from alu_a/alu_b/alu_sel)
//   alu_zero          combinational ALU zero flag
//   wb_valid          one-cycle pulse: a writeback happened at the last edge
//   wb_rd/wb_data     destination and data of that writeback
//   wb_zero           ALU zero flag captured with that writeback
//   dbg_addr/dbg_data combinational register-file peek (no bypass)
// ----------------------------------------------------------------------------
module alu_issue_wb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [3:0]      in_alu_sel,
    input  logic            stall,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    output logic            alu_valid,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,

    output logic            wb_valid,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_zero,

    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Entry 0 is never written, so it stays at its reset value of zero;
    // every read path still decodes address 0 explicitly.
    logic [XLEN-1:0] rf_q [NREGS];

    logic [XLEN-1:0] alu_a_q,     alu_a_d;
    logic [XLEN-1:0] alu_b_q,     alu_b_d;
    logic [3:0]      alu_sel_q,   alu_sel_d;
    logic            alu_valid_q, alu_valid_d;
    logic [AW-1:0]   issue_rd_q,  issue_rd_d;

    logic            wb_valid_q,  wb_valid_d;
    logic [AW-1:0]   wb_rd_q,     wb_rd_d;
    logic [XLEN-1:0] wb_data_q,   wb_data_d;
    logic            wb_zero_q,   wb_zero_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic            accept;
    logic            wb_fire;
    logic            fwd_en;
    logic            rf_we;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    assign in_ready = !stall;
    assign accept   = in_valid && !stall;

    // The issued instruction retires on every unstalled edge.
    assign wb_fire  = alu_valid_q && !stall;

    // Forwarding is only legal when that retirement really happens at the
    // coming edge and targets a real register; a write to r0 is dropped, so
    // forwarding it would leak a non-zero value into an r0 read.
    assign fwd_en   = wb_fire && (issue_rd_q != '0);
    assign rf_we    = fwd_en;

    // Operand A
    always_comb begin
        op_a = '0;
        if (in_rs1 == '0) begin
            op_a = '0;
        end else if (fwd_en && (issue_rd_q == in_rs1)) begin
            op_a = alu_result;
        end else begin
            op_a = rf_q[in_rs1];
        end
    end

    // Operand B: the immediate bypasses both the read and the forward path.
    always_comb begin
        op_b = '0;
        if (in_use_imm) begin
            op_b = in_imm;
        end else if (in_rs2 == '0) begin
            op_b = '0;
        end else if (fwd_en && (issue_rd_q == in_rs2)) begin
            op_b = alu_result;
        end else begin
            op_b = rf_q[in_rs2];
        end
    end

    // Issue register next state: hold everything while stalled; otherwise
    // alu_valid tracks in_valid and the payload loads only on a transfer.
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        issue_rd_d  = issue_rd_q;
        alu_valid_d = alu_valid_q;
        if (!stall) begin
            alu_valid_d = in_valid;
        end
        if (accept) begin
            alu_a_d    = op_a;
            alu_b_d    = op_b;
            alu_sel_d  = in_alu_sel;
            issue_rd_d = in_rd;
        end
    end

    // Writeback report: pulses on every retirement (r0 included); the
    // payload holds between pulses.
    always_comb begin
        wb_valid_d = wb_fire;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_zero_d  = wb_zero_q;
        if (wb_fire) begin
            wb_rd_d   = issue_rd_q;
            wb_data_d = alu_result;
            wb_zero_d = alu_zero;
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_valid_q <= 1'b0;
            issue_rd_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_zero_q   <= 1'b0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            alu_valid_q <= alu_valid_d;
            issue_rd_q  <= issue_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_zero_q   <= wb_zero_d;
        end
    end

    // Register file: cleared by reset, one write port driven by retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[issue_rd_q] <= alu_result;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign alu_valid = alu_valid_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_zero   = wb_zero_q;

    // Raw architectural contents; an in-flight result is not visible here
    // until the edge that writes it.
    assign dbg_data  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_wb
//
// Bench for alu_issue_wb. Supplies a small combinational ALU, drives directed
// and random instruction streams, and checks the DUT against a program-order
// model: each accepted instruction is executed immediately against an
// architectural register array, and its expected writeback is queued. A
// negedge monitor pops the queue on each wb_valid and tracks the committed
// register state for dbg_data.
// ----------------------------------------------------------------------------
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [3:0]  in_alu_sel;
    logic        stall;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic        alu_valid;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_zero;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_wb #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_alu_sel (in_alu_sel),
        .stall      (stall),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_valid  (alu_valid),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_zero    (wb_zero),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Environment ALU
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << b[4:0];
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_sel);
    assign alu_zero   = (alu_result == 32'd0);

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] res;
    } exp_t;

    exp_t        q[$];
    logic [31:0] arch      [32];   // state after every accepted instruction
    logic [31:0] committed [32];   // state after every observed writeback

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 32; i++) begin
            arch[i]      = 32'd0;
            committed[i] = 32'd0;
        end
    endtask

    task automatic model_accept(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic ui, input logic [3:0] sel);
        exp_t e;
        e.rd  = rd;
        e.a   = (rs1 == 5'd0) ? 32'd0 : arch[rs1];
        e.b   = ui ? imm : ((rs2 == 5'd0) ? 32'd0 : arch[rs2]);
        e.sel = sel;
        e.res = alu_f(e.a, e.b, sel);
        q.push_back(e);
        if (rd != 5'd0) arch[rd] = e.res;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready", 32'(in_ready), 32'(!stall));
            if (wb_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_unexpected: got=wb rd=%0d data=%0h want=no writeback",
                             wb_rd, wb_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("wb rd=%0d data=%0h zero=%0b", wb_rd, wb_data, wb_zero);
                    chk("wb_rd",   32'(wb_rd),   32'(e.rd));
                    chk("wb_data", wb_data,      e.res);
                    chk("wb_zero", 32'(wb_zero), 32'(e.res == 32'd0));
                    if (e.rd != 5'd0) committed[e.rd] = e.res;
                end
            end
            chk("alu_valid", 32'(alu_valid), 32'(q.size() != 0));
            if (alu_valid && q.size() != 0) begin
                chk("alu_a",   alu_a,        q[0].a);
                chk("alu_b",   alu_b,        q[0].b);
                chk("alu_sel", 32'(alu_sel), 32'(q[0].sel));
            end
            chk("dbg_data", dbg_data, committed[dbg_addr]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic ui,
                         input logic [3:0] sel, input logic st);
        in_valid   = v;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_imm     = imm;
        in_use_imm = ui;
        in_alu_sel = sel;
        stall      = st;
        if (v && !st) model_accept(rs1, rs2, rd, imm, ui, sel);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    endtask

    // Advance one edge; return just after the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic chk_wb(input logic [4:0] rd, input logic [31:0] data);
        chk("lit_wb_valid", 32'(wb_valid), 32'd1);
        chk("lit_wb_rd",    32'(wb_rd),    32'(rd));
        chk("lit_wb_data",  wb_data,       data);
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, and optionally
    // sweeps every debug address while reset is held.
    task automatic do_reset(input bit sweep);
        in_valid = 1'b0;
        stall    = 1'b0;
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_alu_a",     alu_a,           32'd0);
        chk("rst_alu_b",     alu_b,           32'd0);
        chk("rst_alu_sel",   32'(alu_sel),    32'd0);
        chk("rst_alu_valid", 32'(alu_valid),  32'd0);
        chk("rst_wb_valid",  32'(wb_valid),   32'd0);
        chk("rst_wb_rd",     32'(wb_rd),      32'd0);
        chk("rst_wb_data",   wb_data,         32'd0);
        chk("rst_wb_zero",   32'(wb_zero),    32'd0);
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        if (sweep) begin
            for (int i = 0; i < 32; i++) begin
                dbg_addr = 5'(i);
                #1;
                chk("rst_dbg", dbg_data, 32'd0);
            end
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        dbg_addr = 5'd0;
        idle();
        model_clear();
        @(negedge clk);
        #2;
        do_reset(1'b1);

        // Immediate loads and a register/forward mixed add
        drive(1'b1, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 4'd0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd2, 32'd7, 1'b1, 4'd0, 1'b0); tick();
        chk_wb(5'd1, 32'd5);
        drive(1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 4'd0, 1'b0); tick();
        chk_wb(5'd2, 32'd7);
        idle(); tick();
        chk_wb(5'd3, 32'd12);
        dbg_addr = 5'd3;
        #1;
        chk("lit_dbg_r3", dbg_data, 32'd12);

        // Forwarding chain
        drive(1'b1, 5'd0, 5'd0, 5'd1, 32'd10, 1'b1, 4'd0, 1'b0); tick();
        drive(1'b1, 5'd1, 5'd0, 5'd1, 32'd3,  1'b1, 4'd1, 1'b0); tick();
        chk_wb(5'd1, 32'd10);
        drive(1'b1, 5'd1, 5'd1, 5'd4, 32'd0,  1'b0, 4'd2, 1'b0); tick();
        chk_wb(5'd1, 32'd7);
        idle(); tick();
        chk_wb(5'd4, 32'd49);

        // r0 protection and a zero result
        drive(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 4'd0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 32'd1, 1'b1, 4'd0, 1'b0); tick();
        chk_wb(5'd0, 32'hFFFF_FFFF);
        chk("lit_wb_zero0", 32'(wb_zero), 32'd0);
        drive(1'b1, 5'd5, 5'd0, 5'd8, 32'd1, 1'b1, 4'd1, 1'b0); tick();
        chk_wb(5'd5, 32'd1);
        idle(); tick();
        chk_wb(5'd8, 32'd0);
        chk("lit_wb_zero1", 32'(wb_zero), 32'd1);
        dbg_addr = 5'd0;
        #1;
        chk("lit_dbg_r0", dbg_data, 32'd0);
        dbg_addr = 5'd5;
        #1;
        chk("lit_dbg_r5", dbg_data, 32'd1);

        // Stall for three cycles with in_valid held high
        drive(1'b1, 5'd0, 5'd0, 5'd6, 32'd9, 1'b1, 4'd0, 1'b0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd3, 5'd3, 5'd9, 32'd55, 1'b1, 4'd0, 1'b1); tick();
            chk("lit_stall_ready", 32'(in_ready),  32'd0);
            chk("lit_stall_a",     alu_a,          32'd0);
            chk("lit_stall_b",     alu_b,          32'd9);
            chk("lit_stall_valid", 32'(alu_valid), 32'd1);
            chk("lit_stall_wb",    32'(wb_valid),  32'd0);
        end
        idle(); tick();
        chk_wb(5'd6, 32'd9);
        idle(); tick();
        chk("lit_wb_once", 32'(wb_valid), 32'd0);

        // Reset while an instruction is in flight
        drive(1'b1, 5'd0, 5'd0, 5'd7, 32'd4, 1'b1, 4'd0, 1'b0); tick();
        chk("lit_inflight", 32'(alu_valid), 32'd1);
        do_reset(1'b1);
        idle(); tick();
        chk("lit_rst_no_wb", 32'(wb_valid), 32'd0);
        dbg_addr = 5'd7;
        #1;
        chk("lit_rst_r7", dbg_data, 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1'b0);
            end else begin
                logic [4:0]  rs1, rs2, rd;
                logic [31:0] imm;
                rs1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
                rs2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
                rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
                imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
                drive(1'($urandom_range(0, 3) != 0), rs1, rs2, rd, imm,
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                      1'($urandom_range(0, 4) == 0));
                dbg_addr = 5'($urandom_range(0, 31));
                tick();
            end
        end

        // Drain and confirm nothing is lost
        for (int k = 0; k < 3; k++) begin
            idle(); tick();
        end
        chk("drain_empty", 32'(q.size()), 32'd0);

        do_reset(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Operand-issue and writeback stage wrapped around the combinational ALU.
- Holds the 32-entry integer register file and accepts decoded instructions over a valid/ready handshake.
- Registers the ALU operands and opcode for one cycle, then writes the ALU result back into the register file.
- Forwards the in-flight result so back-to-back dependent instructions never stall.

Parameters:
- XLEN, 32, data width of registers, operands and results.
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero.
- AW, 5, register address width; AW = log2(NREGS).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept; equals !stall.
- in_rs1  input  AW  source register for operand A.
- in_rs2  input  AW  source register for operand B.
- in_rd  input  AW  destination register.
- in_imm  input  XLEN  immediate value.
- in_use_imm  input  1  1: operand B = in_imm; 0: operand B = reg[in_rs2].
- in_alu_sel  input  4  ALU opcode, passed through unchanged.
- stall  input  1  freezes the stage.
- alu_a  output  XLEN  registered operand A to the ALU.
- alu_b  output  XLEN  registered operand B to the ALU.
- alu_sel  output  4  registered opcode to the ALU.
- alu_valid  output  1  issue register holds a live instruction.
- alu_result  input  XLEN  ALU output, combinational from alu_a/alu_b/alu_sel.
- alu_zero  input  1  ALU zero flag.
- wb_valid  output  1  one-cycle pulse: a writeback occurred at the last edge.
- wb_rd  output  AW  destination of that writeback.
- wb_data  output  XLEN  data written.
- wb_zero  output  1  captured alu_zero of that instruction.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  XLEN  combinational reg[dbg_addr]; no bypass; 0 for address 0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all registers cleared to 0.
  - alu_a, alu_b, alu_sel, alu_valid, wb_valid, wb_rd, wb_data and wb_zero all 0.
  - takes effect immediately, mid-operation included; any in-flight instruction is discarded and never written back.
- Accept: a transfer happens on an edge with in_valid && in_ready.
  - issue registers load the operands, alu_sel and rd; alu_valid=1.
  - in_valid=0 with stall=0: alu_valid=0 at the next edge (bubble).
- Operand select, evaluated in the accept cycle:
  - rs==0 gives 0.
  - else, if alu_valid && !stall && issue_rd==rs && issue_rd!=0, forward alu_result.
  - else read reg[rs].
  - operand B uses in_imm when in_use_imm=1; rs2 is then ignored for both forwarding and the read.
- Writeback, on each edge with alu_valid && !stall:
  - reg[issue_rd] <= alu_result, unless issue_rd==0, in which case no write.
  - wb_valid<=1, wb_rd<=issue_rd, wb_data<=alu_result, wb_zero<=alu_zero.
  - wb_valid is still pulsed when rd==0.
  - on any other edge, wb_valid<=0 and wb_rd/wb_data/wb_zero hold their values.
- Latency: accepted at edge N; ALU evaluates in cycle N..N+1; written back at edge N+1; wb_valid high in cycle N+1..N+2. Throughput is one instruction per clock.
- Stall=1:
  - in_ready=0, so no accept.
  - issue registers and alu_valid hold.
  - no register-file write; wb_valid<=0.
  - the held instruction writes back exactly once, at the first edge with stall=0.
  - no duplicate or lost writebacks across a stall of any length.
- Simultaneous write and read of the same register in one edge is resolved by forwarding, never by a register-file read-after-write.
- Arithmetic lives entirely in the ALU; this block performs no width changes. All values are XLEN, unsigned transport.

Test Plan:
- Reset then idle: assert rst_n=0 mid-clock -> all outputs 0 immediately, dbg_data=0 for every address, in_ready=1.
- Immediate loads: ADD r1=r0+imm 5, then ADD r2=r0+imm 7, then ADD r3=r1+r2 (sel 0000), all back-to-back -> wb_data 5, 7, 12 on consecutive cycles; dbg reads r3=12.
- Forwarding chain: r1=r0+imm 10, then SUB r1=r1-imm 3 (sel 0001), then MUL r4=r1*r1 (sel 0010) back-to-back -> wb_data 10, 7, 49; no stall cycles.
- x0 protection: ADD r0=r0+imm 0xFFFF_FFFF, then ADD r5=r0+imm 1 -> first wb_valid=1 with wb_rd=0, r0 stays 0, r5=1.
- Stall: issue r6=r0+imm 9, then hold stall=1 for 3 cycles -> in_ready=0, alu_a/alu_b held, wb_valid=0 throughout; one wb_valid with data 9 on the first cycle after release.
- Reset mid-op: issue r7=r0+imm 4, pulse rst_n low before the writeback edge -> r7 reads 0, no wb_valid pulse, alu_valid=0.
